// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, stall, flush and halt control for a 5-stage pipeline
//
// Purpose:
//   Decides, every cycle, which pipeline latches load, which are flushed,
//   whether the PC advances and whether instruction fetch may use the shared
//   memory port. It tracks three states: RUN, DWAIT (waiting on a data
//   access) and HALTED (terminal until reset). It also counts stall cycles
//   and flush events, and both counters saturate.
//
// Configuration:
//   PIPE_CTRL_FWD_EN - when defined, forwarding paths exist downstream, so
//                      only a load in EX feeding decode needs a bubble.
//                      When undefined (default), any EX or MEM writer whose
//                      destination matches a decode source holds decode.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   ihit, dhit            instruction fetch / data access complete
//   idrs, idrt, idUsesRt  decode-stage source registers, rt-used flag
//   exWEN, exdest, exDRE  EX-stage register write, destination, load flag
//   memWEN, memdest       MEM-stage register write and destination
//   memDRE, memDWE        MEM-stage data read / write request
//   memHALT               halt instruction has reached MEM
//   exBrTaken             branch/JR resolved taken in EX
//   idJmp                 J/JAL decoded
//   pcW                   PC write enable
//   ifidW/ifidRST ...     per-latch write enable and flush-on-write
//   iREN                  instruction fetch request on the shared port
//   halted                pipeline stopped
//   stall_cnt, flush_cnt  saturating event counters
//   state                 RUN=0, DWAIT=1, HALTED=2

module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [4:0]  idrs,
    input  logic [4:0]  idrt,
    input  logic        idUsesRt,
    input  logic        exWEN,
    input  logic [4:0]  exdest,
    input  logic        exDRE,
    input  logic        memWEN,
    input  logic [4:0]  memdest,
    input  logic        memDRE,
    input  logic        memDWE,
    input  logic        memHALT,
    input  logic        exBrTaken,
    input  logic        idJmp,
    output logic        pcW,
    output logic        ifidW,
    output logic        ifidRST,
    output logic        idexW,
    output logic        idexRST,
    output logic        exmemW,
    output logic        exmemRST,
    output logic        memwbW,
    output logic        memwbRST,
    output logic        iREN,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DWAIT  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic data_pend;
    logic data_stall;
    logic ex_match;
    logic mem_match;
    logic hazard;

    assign data_pend = memDRE | memDWE;

    // Register zero is never a real dependency.
    assign ex_match  = (exdest != 5'd0) &&
                       ((exdest == idrs) || (idUsesRt && (exdest == idrt)));
    assign mem_match = (memdest != 5'd0) &&
                       ((memdest == idrs) || (idUsesRt && (memdest == idrt)));

`ifdef PIPE_CTRL_FWD_EN
    // Forwarding covers everything except a load whose data is not back yet.
    assign hazard = exWEN && exDRE && ex_match;
`else
    // No forwarding: decode waits until neither EX nor MEM will write its sources.
    assign hazard = (exWEN && ex_match) || (memWEN && mem_match);
`endif

    // Once in DWAIT the access is known to be outstanding, so only dhit releases it.
    assign data_stall = (cur_state == S_DWAIT) ? !dhit : (data_pend && !dhit);

    always_comb begin
        pcW       = 1'b0;
        ifidW     = 1'b0;
        ifidRST   = 1'b0;
        idexW     = 1'b0;
        idexRST   = 1'b0;
        exmemW    = 1'b0;
        exmemRST  = 1'b0;
        memwbW    = 1'b0;
        memwbRST  = 1'b0;
        iREN      = 1'b0;
        halted    = 1'b0;
        nxt_state = cur_state;

        if (RST) begin
            nxt_state = S_RUN;
        end else if (cur_state == S_HALTED) begin
            halted    = 1'b1;
            nxt_state = S_HALTED;
        end else if (data_stall) begin
            // Whole pipeline freezes; nothing loads and fetch stays off the port.
            nxt_state = S_DWAIT;
        end else begin
            // Back-end stages always advance once data is not stalling.
            exmemW = 1'b1;
            memwbW = 1'b1;
            // Data side owns the shared port whenever it has an access pending.
            iREN   = !data_pend;

            if (exBrTaken) begin
                // Squash the two wrong-path instructions behind the branch.
                pcW     = 1'b1;
                ifidW   = 1'b1;
                ifidRST = 1'b1;
                idexW   = 1'b1;
                idexRST = 1'b1;
            end else if (idJmp) begin
                // Jump target is known in decode: only the fetched slot is wrong.
                pcW     = 1'b1;
                ifidW   = 1'b1;
                ifidRST = 1'b1;
                idexW   = 1'b1;
            end else if (hazard) begin
                // Hold fetch and decode, inject a bubble into EX.
                pcW     = 1'b0;
                ifidW   = 1'b0;
                idexW   = 1'b1;
                idexRST = 1'b1;
            end else if (!ihit) begin
                // Fetch not back: let decode move on and give it a bubble.
                pcW     = 1'b0;
                ifidW   = 1'b1;
                ifidRST = 1'b1;
                idexW   = 1'b1;
            end else begin
                pcW   = 1'b1;
                ifidW = 1'b1;
                idexW = 1'b1;
            end

            // The halt only retires once MEM/WB actually loads it.
            if (memHALT && memwbW) begin
                nxt_state = S_HALTED;
            end else begin
                nxt_state = S_RUN;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_state <= S_RUN;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            cur_state <= nxt_state;
            if (!pcW && (cur_state != S_HALTED) && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if ((ifidRST || idexRST) && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector bench for pipeline_ctrl
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memwbW, memwbRST}
    localparam logic [8:0] C_NORM  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_IMISS = 9'b0_1_1_1_0_1_0_1_0;
    localparam logic [8:0] C_HAZ   = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] C_BR    = 9'b1_1_1_1_1_1_0_1_0;
    localparam logic [8:0] C_JMP   = 9'b1_1_1_1_0_1_0_1_0;
    localparam logic [8:0] C_STALL = 9'b0_0_0_0_0_0_0_0_0;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit;
    logic [4:0]  idrs, idrt;
    logic        idUsesRt;
    logic        exWEN;
    logic [4:0]  exdest;
    logic        exDRE;
    logic        memWEN;
    logic [4:0]  memdest;
    logic        memDRE, memDWE, memHALT, exBrTaken, idJmp;
    logic        pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memwbW, memwbRST;
    logic        iREN, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state;

    int n_vec = 0;
    int n_bad = 0;

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .idrs(idrs), .idrt(idrt), .idUsesRt(idUsesRt),
        .exWEN(exWEN), .exdest(exdest), .exDRE(exDRE),
        .memWEN(memWEN), .memdest(memdest), .memDRE(memDRE), .memDWE(memDWE),
        .memHALT(memHALT), .exBrTaken(exBrTaken), .idJmp(idJmp),
        .pcW(pcW), .ifidW(ifidW), .ifidRST(ifidRST), .idexW(idexW), .idexRST(idexRST),
        .exmemW(exmemW), .exmemRST(exmemRST), .memwbW(memwbW), .memwbRST(memwbRST),
        .iREN(iREN), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       ihit, dhit;
        logic [4:0] idrs, idrt;
        logic       idUsesRt, exWEN;
        logic [4:0] exdest;
        logic       exDRE, memWEN;
        logic [4:0] memdest;
        logic       memDRE, memDWE, exBrTaken, idJmp;
        logic [8:0] ctrl;
        logic       iren;
        logic [1:0] nstate;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic ih, input logic dh,
                                input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                input logic ew, input logic [4:0] ed, input logic edre,
                                input logic mw, input logic [4:0] md, input logic mdre,
                                input logic mdwe, input logic br, input logic jp,
                                input logic [8:0] c, input logic ir, input logic [1:0] ns);
        vec_t v;
        v.name = nm; v.ihit = ih; v.dhit = dh; v.idrs = rs; v.idrt = rt; v.idUsesRt = ur;
        v.exWEN = ew; v.exdest = ed; v.exDRE = edre; v.memWEN = mw; v.memdest = md;
        v.memDRE = mdre; v.memDWE = mdwe; v.exBrTaken = br; v.idJmp = jp;
        v.ctrl = c; v.iren = ir; v.nstate = ns;
        return v;
    endfunction

    function automatic logic [8:0] ctrl_now();
        return {pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memwbW, memwbRST};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b0; idrs = 5'd0; idrt = 5'd0; idUsesRt = 1'b0;
        exWEN = 1'b0; exdest = 5'd0; exDRE = 1'b0; memWEN = 1'b0; memdest = 5'd0;
        memDRE = 1'b0; memDWE = 1'b0; memHALT = 1'b0; exBrTaken = 1'b0; idJmp = 1'b0;
    endtask

    task automatic set_load_use();
        exWEN = 1'b1; exDRE = 1'b1; exdest = 5'd5; idrs = 5'd5;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; idrs = v.idrs; idrt = v.idrt; idUsesRt = v.idUsesRt;
        exWEN = v.exWEN; exdest = v.exdest; exDRE = v.exDRE; memWEN = v.memWEN;
        memdest = v.memdest; memDRE = v.memDRE; memDWE = v.memDWE;
        exBrTaken = v.exBrTaken; idJmp = v.idJmp; memHALT = 1'b0;
    endtask

    initial begin
        set_idle();
        RST = 1'b1;

        //          name         ih dh rs    rt    ur ew ed    edre mw md    mdre mdwe br jp ctrl                      iren ns
        vecs.push_back(mk("normal",   1, 0, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 5'd4, 0, 0, 0, 0, C_NORM,  1, 2'd0));
        vecs.push_back(mk("imiss",    0, 0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_IMISS, 1, 2'd0));
        vecs.push_back(mk("br_prio",  0, 0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 5'd0, 0, 0, 1, 0, C_BR,    1, 2'd0));
        vecs.push_back(mk("jump",     1, 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, C_JMP,   1, 2'd0));
        vecs.push_back(mk("loaduse",  1, 0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 5'd0, 0, 0, 0, 0, C_HAZ,   1, 2'd0));
        vecs.push_back(mk("ex_alu",   1, 0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 5'd0, 0, 0, 0, 0, FWD ? C_NORM : C_HAZ, 1, 2'd0));
        vecs.push_back(mk("mem_rt",   1, 0, 5'd1, 5'd8, 1, 0, 5'd0, 0, 1, 5'd8, 0, 0, 0, 0, FWD ? C_NORM : C_HAZ, 1, 2'd0));
        vecs.push_back(mk("rt_unused",1, 0, 5'd1, 5'd8, 0, 0, 5'd0, 0, 1, 5'd8, 0, 0, 0, 0, C_NORM,  1, 2'd0));
        vecs.push_back(mk("dest_zero",1, 0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, C_NORM,  1, 2'd0));
        vecs.push_back(mk("dstall",   1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, C_STALL, 0, 2'd1));
        vecs.push_back(mk("dwr_hit",  1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, C_NORM,  0, 2'd0));
        vecs.push_back(mk("ds_vs_br", 1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, C_STALL, 0, 2'd1));
        vecs.push_back(mk("haz_imiss",0, 0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 5'd0, 0, 0, 0, 0, C_HAZ,   1, 2'd0));
        vecs.push_back(mk("jmp_haz",  1, 0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 5'd0, 0, 0, 0, 1, C_JMP,   1, 2'd0));

        // Reset state, with inputs that would otherwise produce a normal advance.
        #2;
        check("rst_ctrl", {23'd0, ctrl_now()}, 32'd0);
        check("rst_iren", {31'd0, iREN}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cnt", {stall_cnt, flush_cnt}, 32'd0);

        foreach (vecs[i]) begin
            do_reset();
            apply(vecs[i]);
            #1;
            check({vecs[i].name, " ctrl"}, {23'd0, ctrl_now()}, {23'd0, vecs[i].ctrl});
            check({vecs[i].name, " iren"}, {31'd0, iREN}, {31'd0, vecs[i].iren});
            @(posedge CLK); #1;
            check({vecs[i].name, " state"}, {30'd0, state}, {30'd0, vecs[i].nstate});
            check({vecs[i].name, " stall"}, {16'd0, stall_cnt}, {31'd0, ~vecs[i].ctrl[8]});
            check({vecs[i].name, " flush"}, {16'd0, flush_cnt},
                  {31'd0, vecs[i].ctrl[6] | vecs[i].ctrl[4]});
        end

        // Data miss: three stalled cycles, then release on dhit.
        do_reset();
        set_idle();
        memDRE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("dmiss ctrl", {23'd0, ctrl_now()}, 32'd0);
            check("dmiss iren", {31'd0, iREN}, 32'd0);
            check("dmiss state", {30'd0, state}, (c == 0) ? 32'd0 : 32'd1);
            @(posedge CLK); #1;
        end
        dhit = 1'b1;
        #1;
        check("dmiss dwait", {30'd0, state}, 32'd1);
        check("dmiss adv", {23'd0, ctrl_now()}, {23'd0, C_NORM});
        check("dmiss adv iren", {31'd0, iREN}, 32'd0);
        @(posedge CLK); #1;
        check("dmiss ret", {30'd0, state}, 32'd0);
        check("dmiss stall_cnt", {16'd0, stall_cnt}, 32'd3);
        check("dmiss flush_cnt", {16'd0, flush_cnt}, 32'd0);

        // Single load-use bubble, then decode proceeds.
        do_reset();
        set_idle();
        set_load_use();
        #1;
        check("lu ctrl", {23'd0, ctrl_now()}, {23'd0, C_HAZ});
        @(posedge CLK); #1;
        set_idle();
        #1;
        check("lu clear", {23'd0, ctrl_now()}, {23'd0, C_NORM});
        @(posedge CLK); #1;
        check("lu stall_cnt", {16'd0, stall_cnt}, 32'd1);
        check("lu flush_cnt", {16'd0, flush_cnt}, 32'd1);

        // No-forwarding build repeats the MEM-writer bubble while it persists.
        do_reset();
        set_idle();
        memWEN = 1'b1; memdest = 5'd8; idrt = 5'd8; idUsesRt = 1'b1;
        repeat (2) begin
            #1;
            check("memhaz ctrl", {23'd0, ctrl_now()}, {23'd0, FWD ? C_NORM : C_HAZ});
            @(posedge CLK); #1;
        end
        check("memhaz stall_cnt", {16'd0, stall_cnt}, FWD ? 32'd0 : 32'd2);

        // Branch beats a same-cycle load-use hazard and an instruction miss.
        do_reset();
        set_idle();
        set_load_use();
        ihit = 1'b0;
        exBrTaken = 1'b1;
        #1;
        check("br ctrl", {23'd0, ctrl_now()}, {23'd0, C_BR});
        @(posedge CLK); #1;
        check("br flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check("br stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Halt: one bubble first so the reset clearing the counters is visible.
        do_reset();
        set_idle();
        set_load_use();
        @(posedge CLK); #1;
        set_idle();
        memHALT = 1'b1;
        #1;
        check("halt adv", {23'd0, ctrl_now()}, {23'd0, C_NORM});
        @(posedge CLK); #1;
        memHALT = 1'b0;
        #1;
        check("halt flag", {31'd0, halted}, 32'd1);
        check("halt state", {30'd0, state}, 32'd2);
        check("halt ctrl", {23'd0, ctrl_now()}, 32'd0);
        check("halt iren", {31'd0, iREN}, 32'd0);
        @(posedge CLK); #1;
        check("halt sticky", {30'd0, state}, 32'd2);
        check("halt stall_cnt", {16'd0, stall_cnt}, 32'd1);
        RST = 1'b1;
        #1;
        check("halt rst state", {30'd0, state}, 32'd0);
        check("halt rst halted", {31'd0, halted}, 32'd0);
        check("halt rst cnt", {stall_cnt, flush_cnt}, 32'd0);
        RST = 1'b0;

        // Halt during a data stall does not retire; reset mid-DWAIT drops to RUN.
        do_reset();
        set_idle();
        memDRE = 1'b1;
        memHALT = 1'b1;
        @(posedge CLK); #1;
        check("ds halt state", {30'd0, state}, 32'd1);
        RST = 1'b1;
        #1;
        check("dw rst state", {30'd0, state}, 32'd0);
        check("dw rst ctrl", {23'd0, ctrl_now()}, 32'd0);
        RST = 1'b0;
        set_idle();
        #1;
        check("dw post rst", {23'd0, ctrl_now()}, {23'd0, C_NORM});
        check("dw post iren", {31'd0, iREN}, 32'd1);

        // Saturation of both counters under a long held hazard.
        do_reset();
        set_idle();
        set_load_use();
        repeat (65540) @(posedge CLK);
        #1;
        check("sat stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        check("sat flush_cnt", {16'd0, flush_cnt}, 32'h0000FFFF);
        check("sat ctrl", {23'd0, ctrl_now()}, {23'd0, C_HAZ});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
